// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit owning the architectural HI/LO registers, with multi-cycle busy latency.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (7-10); otherwise they are reserved.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      temp_hi;
    logic [31:0]      temp_lo;
    logic             pending;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s;
    logic signed [31:0] b_safe_s;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] b_safe_u;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               div_ovf;

    logic             launch;
    logic [CNT_W-1:0] load_cnt;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_wr;

    assign busy = (state == ST_RUN);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // A zero divisor is replaced by 1 so the divider never sees it; that result is never written back.
    assign a_s      = $signed(A);
    assign b_safe_s = (B == 32'd0) ? 32'sd1 : $signed(B);
    assign b_safe_u = (B == 32'd0) ? 32'd1 : B;
    assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign quo_s    = div_ovf ? 32'sh8000_0000 : (a_s / b_safe_s);
    assign rem_s    = div_ovf ? 32'sd0 : (a_s % b_safe_s);
    assign quo_u    = A / b_safe_u;
    assign rem_u    = A % b_safe_u;

    // NOTE: every output of this block gets a default first, so no latch is inferred for unlisted ops.
    always_comb begin
        launch   = 1'b0;
        load_cnt = '0;
        res_hi   = HI;
        res_lo   = LO;
        res_wr   = 1'b0;
        case (op)
            OP_MULT: begin
                launch   = 1'b1;
                load_cnt = CNT_W'(MULT_CYCLES);
                {res_hi, res_lo} = prod_s;
                res_wr   = 1'b1;
            end
            OP_MULTU: begin
                launch   = 1'b1;
                load_cnt = CNT_W'(MULT_CYCLES);
                {res_hi, res_lo} = prod_u;
                res_wr   = 1'b1;
            end
            OP_DIV: begin
                launch   = 1'b1;
                load_cnt = CNT_W'(DIV_CYCLES);
                res_hi   = rem_s;
                res_lo   = quo_s;
                res_wr   = (B != 32'd0);
            end
            OP_DIVU: begin
                launch   = 1'b1;
                load_cnt = CNT_W'(DIV_CYCLES);
                res_hi   = rem_u;
                res_lo   = quo_u;
                res_wr   = (B != 32'd0);
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                launch   = 1'b1;
                load_cnt = CNT_W'(MULT_CYCLES);
                {res_hi, res_lo} = {HI, LO} + prod_s;
                res_wr   = 1'b1;
            end
            OP_MADDU: begin
                launch   = 1'b1;
                load_cnt = CNT_W'(MULT_CYCLES);
                {res_hi, res_lo} = {HI, LO} + prod_u;
                res_wr   = 1'b1;
            end
            OP_MSUB: begin
                launch   = 1'b1;
                load_cnt = CNT_W'(MULT_CYCLES);
                {res_hi, res_lo} = {HI, LO} - prod_s;
                res_wr   = 1'b1;
            end
            OP_MSUBU: begin
                launch   = 1'b1;
                load_cnt = CNT_W'(MULT_CYCLES);
                {res_hi, res_lo} = {HI, LO} - prod_u;
                res_wr   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            temp_hi <= '0;
            temp_lo <= '0;
            pending <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else if (state == ST_RUN) begin
            // Requests arriving while busy are dropped; the hazard unit prevents them.
            if (cnt == CNT_W'(1)) begin
                state   <= ST_IDLE;
                cnt     <= '0;
                pending <= 1'b0;
                if (pending) begin
                    HI <= temp_hi;
                    LO <= temp_lo;
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (start) begin
            if (launch) begin
                state   <= ST_RUN;
                cnt     <= load_cnt;
                temp_hi <= res_hi;
                temp_lo <= res_lo;
                pending <= res_wr;
            end else if (op == OP_MTHI) begin
                HI <= A;
            end else if (op == OP_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule
